// File: rtl/mc6809_bus_trace_fifo.sv
// mc6809_bus_trace_fifo: passive MC6809 bus observer. Each rising CPU read or
// write strobe becomes one {rw, addr, data} entry in a FIFO that drains over a
// valid/ready port. An address trigger stops capture POST_TRIG entries after a
// matching access.
module mc6809_bus_trace_fifo #(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int POST_TRIG = 8
) (
  input  logic          cpu_clk,
  input  logic          cpu_reset_n,
  input  logic          cpu_oe_o,
  input  logic          cpu_we_o,
  input  logic [15:0]   cpu_addr_o,
  input  logic [7:0]    cpu_data_o,
  input  logic [7:0]    cpu_data_i,
  input  logic          trig_en,
  input  logic [15:0]   trig_addr,
  input  logic          trig_clear,
  output logic          trace_valid,
  input  logic          trace_ready,
  output logic [24:0]   trace_data,
  output logic [AW:0]   trace_count,
  output logic [7:0]    drop_cnt,
  output logic          trig_hit,
  output logic          frozen,
  output logic          bus_err
);

  typedef enum logic [1:0] {ST_ARMED, ST_POST, ST_FROZEN} state_t;

  state_t        state, state_nxt;
  logic [7:0]    post_cnt, post_cnt_nxt;
  logic          trig_hit_nxt;

  logic          oe_q, we_q;
  logic          oe_rise, we_rise, ev, match;

  logic          p_valid, p_rw, p_trig;
  logic [15:0]   p_addr;
  logic [7:0]    p_data;

  logic [24:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic          push_req, push_ok, pop;
  logic [24:0]   push_data;

  assign oe_rise   = cpu_oe_o & ~oe_q;
  assign we_rise   = cpu_we_o & ~we_q;
  assign ev        = oe_rise | we_rise;
  assign match     = ev && trig_en && (cpu_addr_o == trig_addr) &&
                     (state == ST_ARMED) && !trig_clear;

  assign trace_valid = (trace_count != '0);
  assign frozen      = (state == ST_FROZEN);
  assign pop         = trace_valid && trace_ready;
  // Anything still in the pipeline when capture froze is thrown away here.
  assign push_req    = p_valid && (state != ST_FROZEN);
  assign push_ok     = push_req && ((trace_count < (AW+1)'(DEPTH)) || pop);
  // Read data is only on the bus the cycle after the strobe rises.
  assign push_data   = {p_rw, p_addr, p_rw ? p_data : cpu_data_i};
  assign rd_nxt      = rd_ptr + AW'(1);

  // Strobe history, event capture stage and sticky bus error flag.
  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      p_valid <= 1'b0;
      p_rw    <= 1'b0;
      p_trig  <= 1'b0;
      p_addr  <= '0;
      p_data  <= '0;
      bus_err <= 1'b0;
    end else begin
      oe_q    <= cpu_oe_o;
      we_q    <= cpu_we_o;
      p_valid <= ev && (state != ST_FROZEN);
      p_rw    <= we_rise;
      p_trig  <= match;
      p_addr  <= cpu_addr_o;
      p_data  <= cpu_data_o;
      if (oe_rise && we_rise)
        bus_err <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge cpu_clk) begin
    if (push_ok)
      mem[wr_ptr] <= push_data;
  end

  // FIFO pointers, occupancy, registered head entry and drop counter.
  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      trace_count <= '0;
      trace_data  <= '0;
      drop_cnt    <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_nxt;
      case ({push_ok, pop})
        2'b10:   trace_count <= trace_count + (AW+1)'(1);
        2'b01:   trace_count <= trace_count - (AW+1)'(1);
        default: trace_count <= trace_count;
      endcase
      // Head register tracks the entry at rd_ptr; when the FIFO is (or is
      // about to become) empty the incoming entry goes straight to the head.
      if (pop) begin
        if (trace_count > (AW+1)'(1))
          trace_data <= mem[rd_nxt];
        else if (push_ok)
          trace_data <= push_data;
      end else if (push_ok && (trace_count == '0)) begin
        trace_data <= push_data;
      end
      if (push_req && !push_ok && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Trigger FSM state, post-trigger counter and sticky hit flag.
  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      state    <= ST_ARMED;
      post_cnt <= '0;
      trig_hit <= 1'b0;
    end else begin
      state    <= state_nxt;
      post_cnt <= post_cnt_nxt;
      trig_hit <= trig_hit_nxt;
    end
  end

  // Trigger next-state logic; the trigger entry itself never decrements.
  always_comb begin
    state_nxt    = state;
    post_cnt_nxt = post_cnt;
    trig_hit_nxt = trig_hit;
    if (trig_clear) begin
      state_nxt    = ST_ARMED;
      trig_hit_nxt = 1'b0;
    end else begin
      case (state)
        ST_ARMED: begin
          if (match) begin
            trig_hit_nxt = 1'b1;
            state_nxt    = ST_POST;
            post_cnt_nxt = 8'(POST_TRIG);
          end
        end
        ST_POST: begin
          if (push_ok) begin
            if (post_cnt == 8'd0) begin
              state_nxt = ST_FROZEN;
            end else if (!p_trig) begin
              post_cnt_nxt = post_cnt - 8'd1;
              if (post_cnt == 8'd1)
                state_nxt = ST_FROZEN;
            end
          end
        end
        ST_FROZEN: state_nxt = ST_FROZEN;
        default:   state_nxt = ST_ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_mc6809_bus_trace_fifo.sv
// Directed bench for mc6809_bus_trace_fifo (DEPTH=16, POST_TRIG=2).
module tb_mc6809_bus_trace_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_oe_o, cpu_we_o;
  logic [15:0]   cpu_addr_o;
  logic [7:0]    cpu_data_o, cpu_data_i;
  logic          trig_en, trig_clear, trace_ready;
  logic [15:0]   trig_addr;
  logic          trace_valid, trig_hit, frozen, bus_err;
  logic [24:0]   trace_data;
  logic [AW:0]   trace_count;
  logic [7:0]    drop_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [24:0] exp;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  mc6809_bus_trace_fifo #(.DEPTH(DEPTH), .AW(AW), .POST_TRIG(2)) dut (
    .cpu_clk     (clk),
    .cpu_reset_n (rst_n),
    .cpu_oe_o    (cpu_oe_o),
    .cpu_we_o    (cpu_we_o),
    .cpu_addr_o  (cpu_addr_o),
    .cpu_data_o  (cpu_data_o),
    .cpu_data_i  (cpu_data_i),
    .trig_en     (trig_en),
    .trig_addr   (trig_addr),
    .trig_clear  (trig_clear),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_data  (trace_data),
    .trace_count (trace_count),
    .drop_cnt    (drop_cnt),
    .trig_hit    (trig_hit),
    .frozen      (frozen),
    .bus_err     (bus_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe pulse held for 'hold' cycles, then one idle cycle.
  task automatic bus(input logic rw, input logic [15:0] a, input logic [7:0] d,
                     input int unsigned hold);
    cpu_addr_o = a;
    if (rw) begin
      cpu_data_o = d;
      cpu_we_o   = 1'b1;
    end else begin
      cpu_data_i = d;
      cpu_oe_o   = 1'b1;
    end
    repeat (hold) tick();
    cpu_oe_o = 1'b0;
    cpu_we_o = 1'b0;
    tick();
  endtask

  task automatic pop_check(input string name, input logic [24:0] exp);
    check({name, "_valid"}, 32'(trace_valid), 32'd1);
    check(name, 32'(trace_data), 32'(exp));
    trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 16'h0001, 8'h5A, 25'h100015A};
    vecs[1] = '{1'b0, 16'h1000, 8'h86, 25'h0100086};
    vecs[2] = '{1'b1, 16'hFFFF, 8'h00, 25'h1FFFF00};
    vecs[3] = '{1'b0, 16'h0000, 8'hFF, 25'h00000FF};
    vecs[4] = '{1'b1, 16'h8421, 8'hC3, 25'h18421C3};
    vecs[5] = '{1'b0, 16'hABCD, 8'h3C, 25'h0ABCD3C};

    rst_n = 1'b0; cpu_oe_o = 1'b0; cpu_we_o = 1'b0; cpu_addr_o = '0;
    cpu_data_o = '0; cpu_data_i = '0; trig_en = 1'b0; trig_addr = '0;
    trig_clear = 1'b0; trace_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(trace_valid), 32'd0);
    check("rst_count", 32'(trace_count), 32'd0);
    check("rst_data",  32'(trace_data),  32'd0);
    check("rst_drop",  32'(drop_cnt),    32'd0);
    check("rst_flags", {28'd0, trig_hit, frozen, bus_err, 1'b0}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Capture latency: write held two cycles is one entry, valid 2 clocks after rise.
    cpu_addr_o = 16'h0001; cpu_data_o = 8'h5A; cpu_we_o = 1'b1;
    tick();
    check("lat_valid_1clk", 32'(trace_valid), 32'd0);
    tick();
    check("lat_valid_2clk", 32'(trace_valid), 32'd1);
    cpu_we_o = 1'b0;
    tick(); tick();
    check("lat_count_held", 32'(trace_count), 32'd1);
    pop_check("lat_entry", 25'h100015A);
    check("lat_empty", 32'(trace_valid), 32'd0);

    // Table of single transactions, buffered then drained in order.
    foreach (vecs[i]) bus(vecs[i].rw, vecs[i].addr, vecs[i].data, 2);
    check("tab_count", 32'(trace_count), 32'd6);
    foreach (vecs[i]) pop_check($sformatf("tab%0d", i), vecs[i].exp);
    check("tab_empty", 32'(trace_count), 32'd0);

    // Back-to-back read then write in consecutive cycles.
    cpu_addr_o = 16'h3000; cpu_data_i = 8'h11; cpu_oe_o = 1'b1;
    tick();
    cpu_oe_o = 1'b0; cpu_addr_o = 16'h3001; cpu_data_o = 8'h22; cpu_we_o = 1'b1;
    tick();
    cpu_we_o = 1'b0;
    tick();
    check("b2b_count", 32'(trace_count), 32'd2);
    pop_check("b2b_read",  25'h0300011);
    pop_check("b2b_write", 25'h1300122);

    // 20 writes into a 16-deep FIFO with no consumer.
    for (int i = 0; i < 20; i++) bus(1'b1, 16'(i), 8'(i), 1);
    tick();
    check("ovf_count", 32'(trace_count), 32'd16);
    check("ovf_drop",  32'(drop_cnt),    32'd4);
    for (int i = 0; i < 16; i++) pop_check($sformatf("ovf%0d", i), {1'b1, 16'(i), 8'(i)});
    check("ovf_drained", 32'(trace_valid), 32'd0);

    // Full FIFO: push and pop land on the same edge.
    for (int i = 0; i < 16; i++) bus(1'b1, 16'h0200 + 16'(i), 8'(i), 1);
    check("full_count", 32'(trace_count), 32'd16);
    cpu_addr_o = 16'h0300; cpu_data_o = 8'hEE; cpu_we_o = 1'b1;
    tick();
    cpu_we_o = 1'b0; trace_ready = 1'b1;
    tick();
    trace_ready = 1'b0;
    check("full_pp_count", 32'(trace_count), 32'd16);
    check("full_pp_drop",  32'(drop_cnt),    32'd4);
    for (int i = 1; i < 16; i++)
      pop_check($sformatf("full%0d", i), {1'b1, 16'h0200 + 16'(i), 8'(i)});
    pop_check("full_new", 25'h10300EE);
    check("full_drained", 32'(trace_valid), 32'd0);

    // Trigger at the reset vector with two post-trigger entries.
    trig_en = 1'b1; trig_addr = 16'hFFFE;
    bus(1'b0, 16'h0100, 8'h01, 1);
    check("trg_hit_pre", 32'(trig_hit), 32'd0);
    bus(1'b0, 16'hFFFE, 8'h12, 1);
    check("trg_hit", 32'(trig_hit), 32'd1);
    check("trg_not_frozen", 32'(frozen), 32'd0);
    bus(1'b0, 16'hFFFF, 8'h34, 1);
    check("trg_post1_frozen", 32'(frozen), 32'd0);
    bus(1'b0, 16'h1234, 8'hAA, 1);
    check("trg_frozen", 32'(frozen), 32'd1);
    bus(1'b0, 16'h1235, 8'hBB, 1);
    check("trg_ignored_count", 32'(trace_count), 32'd4);
    trig_clear = 1'b1;
    tick();
    trig_clear = 1'b0;
    check("clr_frozen", 32'(frozen), 32'd0);
    check("clr_hit",    32'(trig_hit), 32'd0);
    bus(1'b0, 16'h2000, 8'h55, 1);
    check("clr_resume_count", 32'(trace_count), 32'd5);
    // Clear on the same cycle as a match wins.
    cpu_addr_o = 16'hFFFE; cpu_data_i = 8'h66; cpu_oe_o = 1'b1; trig_clear = 1'b1;
    tick();
    cpu_oe_o = 1'b0; trig_clear = 1'b0;
    tick();
    check("clr_prio_hit", 32'(trig_hit), 32'd0);
    check("clr_prio_count", 32'(trace_count), 32'd6);
    trig_en = 1'b0;
    pop_check("trg_e0", 25'h0010001);
    pop_check("trg_e1", 25'h0FFFE12);
    pop_check("trg_e2", 25'h0FFFF34);
    pop_check("trg_e3", 25'h01234AA);
    pop_check("trg_e4", 25'h0200055);
    pop_check("trg_e5", 25'h0FFFE66);

    // Both strobes rising together.
    check("berr_pre", 32'(bus_err), 32'd0);
    cpu_addr_o = 16'h4444; cpu_data_o = 8'h77; cpu_data_i = 8'h99;
    cpu_oe_o = 1'b1; cpu_we_o = 1'b1;
    tick();
    cpu_oe_o = 1'b0; cpu_we_o = 1'b0;
    tick();
    check("berr_flag",  32'(bus_err), 32'd1);
    check("berr_count", 32'(trace_count), 32'd1);
    pop_check("berr_entry", 25'h1444477);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) bus(1'b1, 16'h5000 + 16'(i), 8'(i), 1);
    cpu_addr_o = 16'h5003; cpu_data_o = 8'h33; cpu_we_o = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(trace_count), 32'd0);
    check("arst_valid", 32'(trace_valid), 32'd0);
    check("arst_data",  32'(trace_data),  32'd0);
    check("arst_drop",  32'(drop_cnt),    32'd0);
    check("arst_berr",  32'(bus_err),     32'd0);
    cpu_we_o = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("arst_inflight_lost", 32'(trace_count), 32'd0);
    bus(1'b1, 16'h6000, 8'hA5, 1);
    pop_check("post_rst_entry", 25'h16000A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
